// File: rtl/frame_generator_impl_if.sv
// AXI4-Stream bus carrying generated Ethernet/IPv4 test frames.
interface frame_generator_impl_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 3
);
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] keep;
   logic                    last;
   logic [DATA_WIDTH/8-1:0] user;
   logic [ID_WIDTH-1:0]     id;
   logic                    valid;
   logic                    ready;

   modport master (output data, keep, last, user, id, valid, input ready);
   modport slave  (input data, keep, last, user, id, valid, output ready);
endinterface

// File: rtl/frame_generator_impl.sv
// Back-to-back Ethernet/IPv4 test frame generator with LFSR payload and
// running frame/byte counters, streaming 64-byte beats on AXIS.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h00
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module frame_generator_impl #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 3
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic                start,
   input  logic                stop,
   input  logic [15:0]         cfg_frame_len,
   input  logic [15:0]         cfg_seed,
   input  logic [47:0]         cfg_eth_dst,
   input  logic [47:0]         cfg_eth_src,
   input  logic [31:0]         cfg_ip_src,
   input  logic [31:0]         cfg_ip_dst,
   input  logic [ID_WIDTH-1:0] cfg_port_id,
   output logic [63:0]         sent_frames,
   output logic [63:0]         sent_bytes,
   frame_generator_impl_if.master axis_m
);
   localparam int          KEEP_W  = DATA_WIDTH / 8;
   localparam logic [15:0] LEN_MIN = 16'd60;
   localparam logic [15:0] LEN_MAX = 16'd1514;
   localparam logic [15:0] BEAT_B  = 16'd64;
   localparam logic [7:0]  TOS     = `TEST_FRAME_TOS;
   localparam logic [7:0]  PROTO   = `TEST_FRAME_PROTO;

   typedef enum logic [1:0] {IDLE, FIRST, BODY} state_t;

   state_t state, state_nxt;

   logic [15:0]         len_q;
   logic [15:0]         rem_q;
   logic [15:0]         frame_id;
   logic [15:0]         pat_q;
   logic [47:0]         eth_dst_q;
   logic [47:0]         eth_src_q;
   logic [31:0]         ip_src_q;
   logic [31:0]         ip_dst_q;
   logic [ID_WIDTH-1:0] port_id_q;
   logic                stop_flag;

   logic                active;
   logic                hs;
   logic                accept;
   logic                last_beat;
   logic                frame_end;
   logic [15:0]         len_clamped;
   logic [15:0]         word;
   logic [15:0]         tot_len;
   logic [15:0]         csum;
   logic [271:0]        hdr;
   logic [DATA_WIDTH-1:0] data_c;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [15:0] clamp_len(input logic [15:0] l);
      if (l < LEN_MIN) return LEN_MIN;
      if (l > LEN_MAX) return LEN_MAX;
      return l;
   endfunction

   function automatic logic [KEEP_W-1:0] keep_mask(input logic [5:0] r);
      if (r == 6'd0) return '1;
      return (64'h1 << r) - 64'h1;
   endfunction

   // Words are big-endian byte pairs as they appear on the wire.
   function automatic logic [15:0] ip_csum(input logic [15:0] tl,
                                           input logic [15:0] id,
                                           input logic [31:0] ip_s,
                                           input logic [31:0] ip_d);
      logic [19:0] sum;
      logic [16:0] fold;
      sum = {4'h0, 8'h45, TOS} + {4'h0, tl} + {4'h0, id} + {4'h0, 8'd64, PROTO}
          + {4'h0, ip_s[7:0], ip_s[15:8]}  + {4'h0, ip_s[23:16], ip_s[31:24]}
          + {4'h0, ip_d[7:0], ip_d[15:8]}  + {4'h0, ip_d[23:16], ip_d[31:24]};
      fold = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
      return ~(fold[15:0] + {15'h0, fold[16]});
   endfunction

   assign active      = (state != IDLE);
   assign hs          = active && !rst && axis_m.ready;
   assign accept      = (state == IDLE) && start;
   assign last_beat   = (rem_q <= BEAT_B);
   assign frame_end   = hs && last_beat;
   assign len_clamped = clamp_len(cfg_frame_len);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = FIRST;
         end
         FIRST, BODY: begin
            if (hs) begin
               if (last_beat) state_nxt = (stop_flag || stop) ? IDLE : FIRST;
               else           state_nxt = BODY;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stop_flag   <= 1'b0;
         sent_frames <= 64'd0;
         sent_bytes  <= 64'd0;
         frame_id    <= 16'd0;
      end else begin
         if (frame_end && (stop_flag || stop)) stop_flag <= 1'b0;
         else if (stop && active)              stop_flag <= 1'b1;
         if (accept) begin
            sent_frames <= 64'd0;
            sent_bytes  <= 64'd0;
            frame_id    <= cfg_seed;
         end else if (frame_end) begin
            sent_frames <= sent_frames + 64'd1;
            sent_bytes  <= sent_bytes + {48'd0, len_q};
            frame_id    <= lfsr_step(frame_id);
         end
      end
   end

   // Configuration is only captured at start, so it stays stable across stalls.
   always_ff @(posedge clk) begin
      if (accept) begin
         len_q     <= len_clamped;
         eth_dst_q <= cfg_eth_dst;
         eth_src_q <= cfg_eth_src;
         ip_src_q  <= cfg_ip_src;
         ip_dst_q  <= cfg_ip_dst;
         port_id_q <= cfg_port_id;
      end
      if (accept)         rem_q <= len_clamped;
      else if (frame_end) rem_q <= len_q;
      else if (hs)        rem_q <= rem_q - BEAT_B;
      if (hs) pat_q <= lfsr_step(word);
   end

   assign word    = (state == FIRST) ? frame_id : pat_q;
   assign tot_len = len_q - 16'd14;
   assign csum    = ip_csum(tot_len, frame_id, ip_src_q, ip_dst_q);

   // Concatenation runs from byte 33 (MSB) down to byte 0 (LSB).
   assign hdr = {ip_dst_q, ip_src_q, csum[7:0], csum[15:8], PROTO, 8'd64, 16'h0000,
                 frame_id[7:0], frame_id[15:8], tot_len[7:0], tot_len[15:8],
                 TOS, 8'h45, 8'h00, 8'h08, eth_src_q, eth_dst_q};

   always_comb begin
      for (int j = 0; j < DATA_WIDTH / 16; j++) data_c[16*j +: 16] = {word[7:0], word[15:8]};
      if (state == FIRST) data_c[271:0] = hdr;
   end

   assign axis_m.valid = active && !rst;
   assign axis_m.data  = data_c;
   assign axis_m.keep  = last_beat ? keep_mask(rem_q[5:0]) : '1;
   assign axis_m.last  = last_beat;
   assign axis_m.user  = '0;
   assign axis_m.id    = port_id_q;
endmodule

// File: tb/tb_frame_generator_impl.sv
// Directed bench for frame_generator_impl: header/payload/keep per beat,
// stop handling, length clamping, backpressure stability and reset abandonment.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h00
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module tb_frame_generator_impl;
   localparam int          DW    = 512;
   localparam int          IW    = 3;
   localparam logic [47:0] DST   = 48'h665544332211;
   localparam logic [47:0] SRC   = 48'hCCBBAA998877;
   localparam logic [31:0] IPS   = 32'h0A01A8C0;
   localparam logic [31:0] IPD   = 32'h1402A8C0;
   localparam logic [IW-1:0] PID = 3'd5;
   localparam logic [7:0]  TOS   = `TEST_FRAME_TOS;
   localparam logic [7:0]  PROTO = `TEST_FRAME_PROTO;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        ready;
   logic [15:0] cfg_frame_len = 16'd60;
   logic [15:0] cfg_seed = 16'd1;
   logic [63:0] sent_frames;
   logic [63:0] sent_bytes;
   int          n_checks = 0;
   int          n_pass = 0;

   frame_generator_impl_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) axis ();

   frame_generator_impl #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop),
      .cfg_frame_len(cfg_frame_len), .cfg_seed(cfg_seed),
      .cfg_eth_dst(DST), .cfg_eth_src(SRC), .cfg_ip_src(IPS), .cfg_ip_dst(IPD),
      .cfg_port_id(PID), .sent_frames(sent_frames), .sent_bytes(sent_bytes),
      .axis_m(axis)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [15:0] lfsr(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [511:0] exp_data(input int len, input int k,
                                             input logic [15:0] id, input logic [15:0] w);
      logic [7:0]   b [64];
      logic [511:0] d;
      logic [15:0]  tl;
      logic [31:0]  s;
      logic [15:0]  cs;
      for (int i = 0; i < 64; i++) b[i] = (i % 2 == 0) ? w[15:8] : w[7:0];
      if (k == 1) begin
         for (int i = 0; i < 6; i++) begin
            b[i] = DST[8*i +: 8];
            b[6+i] = SRC[8*i +: 8];
         end
         tl = 16'(len - 14);
         b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[15] = TOS;
         b[16] = tl[15:8]; b[17] = tl[7:0]; b[18] = id[15:8]; b[19] = id[7:0];
         b[20] = 8'h00; b[21] = 8'h00; b[22] = 8'd64; b[23] = PROTO;
         b[24] = 8'h00; b[25] = 8'h00;
         for (int i = 0; i < 4; i++) begin
            b[26+i] = IPS[8*i +: 8];
            b[30+i] = IPD[8*i +: 8];
         end
         s = 32'd0;
         for (int i = 14; i < 34; i += 2) s = s + {16'h0, b[i], b[i+1]};
         while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
         cs = ~s[15:0];
         b[24] = cs[15:8]; b[25] = cs[7:0];
      end
      for (int i = 0; i < 64; i++) d[8*i +: 8] = b[i];
      return d;
   endfunction

   task automatic run_frames(input logic [15:0] len_cfg, input int len_eff,
                             input logic [15:0] seed, input int n, input bit bp,
                             input bit poke, input bit csum_chk);
      int           cyc, done, k, nb;
      logic [15:0]  id, w;
      logic [511:0] ed;
      logic [63:0]  ek;
      logic         el;
      logic         pending;
      logic [576:0] snap;
      bit           stop_sent, poked;
      logic [31:0]  s;
      nb = (len_eff + 63) / 64;
      cfg_frame_len = len_cfg;
      cfg_seed = seed;
      axis.ready = 1'b1;
      if (poke) begin
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end
      n_checks++;
      if (ready !== 1'b1) $display("FAIL ready_before_start got=%b exp=1", ready);
      else n_pass++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (axis.valid !== 1'b1) $display("FAIL first_beat_valid got=%b exp=1", axis.valid);
      else n_pass++;
      id = seed; w = seed; k = 1; done = 0; cyc = 0;
      pending = 1'b0; stop_sent = 1'b0; poked = 1'b0; snap = '0;
      while (done < n && cyc < 2000) begin
         stop = 1'b0;
         start = 1'b0;
         axis.ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (pending) begin
            n_checks++;
            if ({axis.valid, axis.data, axis.keep, axis.last} !== {1'b1, snap})
               $display("FAIL stall_stable frame=%0d beat=%0d got_valid=%b", done, k, axis.valid);
            else n_pass++;
         end
         if (axis.valid) begin
            ed = exp_data(len_eff, k, id, w);
            for (int i = 0; i < 64; i++)
               ek[i] = (k < nb) || (len_eff % 64 == 0) || (i < len_eff % 64);
            el = (k == nb);
            n_checks++;
            if (axis.data !== ed)
               $display("FAIL data frame=%0d beat=%0d got=%h exp=%h", done, k, axis.data, ed);
            else n_pass++;
            n_checks++;
            if ({axis.keep, axis.last, axis.user, axis.id} !== {ek, el, 64'h0, PID})
               $display("FAIL ctrl frame=%0d beat=%0d keep=%h/%h last=%b/%b user=%h id=%0d/%0d",
                        done, k, axis.keep, ek, axis.last, el, axis.user, axis.id, PID);
            else n_pass++;
            if (csum_chk && k == 1 && done == 0) begin
               s = 32'd0;
               for (int i = 14; i < 34; i += 2)
                  s = s + {16'h0, axis.data[8*i +: 8], axis.data[8*(i+1) +: 8]};
               while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
               n_checks++;
               if (s[15:0] !== 16'hFFFF) $display("FAIL checksum_verify got=%h exp=ffff", s[15:0]);
               else n_pass++;
               n_checks++;
               if ({axis.data[135:128], axis.data[143:136]} !== 16'(len_eff - 14))
                  $display("FAIL total_len got=%0d exp=%0d",
                           {axis.data[135:128], axis.data[143:136]}, len_eff - 14);
               else n_pass++;
            end
            if (done == n - 1 && k == 1 && !stop_sent) begin
               stop = 1'b1;
               stop_sent = 1'b1;
            end
            if (poke && done == 1 && k == 1 && !poked) begin
               start = 1'b1;
               cfg_frame_len = 16'd300;
               poked = 1'b1;
            end
            if (axis.ready) begin
               pending = 1'b0;
               if (k == nb) begin
                  done++;
                  id = lfsr(id);
                  w = id;
                  k = 1;
               end else begin
                  k++;
                  w = lfsr(w);
               end
            end else begin
               pending = 1'b1;
               snap = {axis.data, axis.keep, axis.last};
            end
         end else pending = 1'b0;
         @(negedge clk);
         cyc++;
      end
      stop = 1'b0;
      start = 1'b0;
      n_checks++;
      if (done != n) $display("FAIL frames_completed got=%0d exp=%0d (cycle budget)", done, n);
      else n_pass++;
      n_checks++;
      if ({ready, axis.valid} !== 2'b10)
         $display("FAIL idle_after_stop ready=%b valid=%b exp ready=1 valid=0", ready, axis.valid);
      else n_pass++;
      n_checks++;
      if ({sent_frames, sent_bytes} !== {64'(n), 64'(n * len_eff)})
         $display("FAIL counters got=%0d/%0d exp=%0d/%0d", sent_frames, sent_bytes, n, n * len_eff);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sent_frames, sent_bytes} !== {64'(n), 64'(n * len_eff)})
         $display("FAIL counters_hold got=%0d/%0d exp=%0d/%0d", sent_frames, sent_bytes, n, n * len_eff);
      else n_pass++;
   endtask

   task automatic test_reset();
      axis.ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (axis.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", axis.valid);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({ready, sent_frames, sent_bytes} !== {1'b1, 64'd0, 64'd0})
         $display("FAIL reset_state ready=%b frames=%0d bytes=%0d exp 1/0/0", ready, sent_frames, sent_bytes);
      else n_pass++;
      @(negedge clk);
   endtask

   // Three minimum frames, seed 1: IDs 0x0001, 0x8000, 0x4000; 180 bytes total.
   // Also pulses stop while idle and start mid-run; neither may change anything.
   task automatic test_single_beat();
      run_frames(16'd60, 60, 16'h0001, 3, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_two_beat();
      run_frames(16'd128, 128, 16'hACE1, 2, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_clamp();
      run_frames(16'd20, 60, 16'h1234, 1, 1'b0, 1'b0, 1'b1);
      run_frames(16'd4000, 1514, 16'hBEEF, 1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      run_frames(16'd1514, 1514, 16'h5A5A, 1, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_frames(16'd100, 100, 16'h0F0F, 3, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_midframe_reset();
      int hs, cyc;
      cfg_frame_len = 16'd1514;
      cfg_seed = 16'h0001;
      axis.ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs = 0;
      cyc = 0;
      while (cyc < 500) begin
         if (axis.valid) begin
            if (hs == 28) break;
            hs++;
         end
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if ({hs, sent_frames} !== {32'd28, 64'd1})
         $display("FAIL pre_reset_progress beats=%0d frames=%0d exp 28/1", hs, sent_frames);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (axis.valid !== 1'b0) $display("FAIL valid_during_rst got=%b exp=0", axis.valid);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({ready, axis.valid, sent_frames, sent_bytes} !== {2'b10, 64'd0, 64'd0})
         $display("FAIL after_midframe_reset ready=%b valid=%b frames=%0d bytes=%0d exp 1/0/0/0",
                  ready, axis.valid, sent_frames, sent_bytes);
      else n_pass++;
      @(negedge clk);
      run_frames(16'd60, 60, 16'h0002, 1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      axis.ready = 1'b1;
      test_reset();
      test_single_beat();
      test_two_beat();
      test_clamp();
      test_backpressure();
      test_back_to_back();
      test_midframe_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
